// File: rtl/cart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : cart_loader
//  Description : Cartridge load stage between the ioctl download stream and
//                the console core. Forwards accepted ROM writes (registered),
//                tracks the loaded image size, decodes the file extension
//                into a bank-switch scheme and decides SuperChip RAM enable.
//                Results are latched once per download and held until the
//                next download completes.
//  Ports       : clk_sys, reset (sync, active-high)
//                ioctl_download/wr/addr/dout/file_ext : HPS download stream
//                sc_mode   : SuperChip select (0 auto, 1 off, 2/3 on)
//                rom_we/wa/wd : registered ROM write port
//                rom_size, force_bs, sc : per-download results
//                busy : load in progress, done : one-cycle results-valid pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module cart_loader #(
    parameter int ADDR_W = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [31:0]       ioctl_file_ext,
    input  logic [1:0]        sc_mode,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_wa,
    output logic [7:0]        rom_wd,
    output logic [16:0]       rom_size,
    output logic [3:0]        force_bs,
    output logic              sc,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    localparam logic [16:0] c_SIZE_8K  = 17'd8192;
    localparam logic [16:0] c_SIZE_16K = 17'd16384;
    localparam logic [16:0] c_SIZE_32K = 17'd32768;

    state_t      r_state;
    logic        r_dl_prev;
    logic        r_rise_pend;
    logic [16:0] r_size;
    logic        r_sc_data;
    logic [7:0]  r_ref;
    logic [1:0]  r_mode;
    logic [3:0]  r_bs;
    logic        r_ext_s;

    logic        w_rise;
    logic        w_fall;
    logic        w_accept;
    logic [23:0] w_ext;
    logic [3:0]  w_bs_dec;
    logic [16:0] w_end;
    logic        w_addr_zero;
    logic        w_low_page;
    logic        w_size_ok;
    logic        w_sc_auto;

    assign w_rise   = ioctl_download & ~r_dl_prev;
    assign w_fall   = ~ioctl_download & r_dl_prev;
    assign w_accept = (r_state == S_LOAD) & ioctl_wr & (ioctl_addr[24:ADDR_W] == '0);

    // Extensions arrive right-aligned; a 3-char name with the dot sits in the
    // low 24 bits, a 4-char one (e.g. ".F6S") has the dot one byte higher.
    assign w_ext = (ioctl_file_ext[23:16] == 8'h2E) ? ioctl_file_ext[23:0]
                                                    : ioctl_file_ext[31:8];

    always_comb begin
        w_bs_dec = 4'd0;
        case (w_ext)
            ".F8":   w_bs_dec = 4'd1;
            ".F6":   w_bs_dec = 4'd2;
            ".FE":   w_bs_dec = 4'd3;
            ".E0":   w_bs_dec = 4'd4;
            ".3F":   w_bs_dec = 4'd5;
            ".F4":   w_bs_dec = 4'd6;
            ".P2":   w_bs_dec = 4'd7;
            ".FA":   w_bs_dec = 4'd8;
            ".CV":   w_bs_dec = 4'd9;
            ".UA":   w_bs_dec = 4'd11;
            ".E7":   w_bs_dec = 4'd12;
            ".F0":   w_bs_dec = 4'd13;
            ".32":   w_bs_dec = 4'd14;
            default: w_bs_dec = 4'd0;
        endcase
    end

    // 17-bit end address so a write to the last byte yields the full 64 KB.
    assign w_end       = 17'(ioctl_addr[ADDR_W-1:0]) + 17'd1;
    assign w_addr_zero = (ioctl_addr[ADDR_W-1:0] == '0);
    assign w_low_page  = (ioctl_addr[ADDR_W-1:8] == '0);
    assign w_size_ok   = (r_size == c_SIZE_8K) | (r_size == c_SIZE_16K) |
                         (r_size == c_SIZE_32K);
    // Auto mode: explicit "S" suffix, or a uniform first page (the SuperChip
    // RAM window reads back as fill) in a standard-size image.
    assign w_sc_auto   = r_ext_s | (r_sc_data & w_size_ok);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            // Treat the line as already high so a download in progress across
            // reset is not mistaken for a new one.
            r_dl_prev   <= 1'b1;
            r_rise_pend <= 1'b0;
            r_size      <= '0;
            r_sc_data   <= 1'b0;
            r_ref       <= '0;
            r_mode      <= '0;
            r_bs        <= '0;
            r_ext_s     <= 1'b0;
            rom_we      <= 1'b0;
            rom_wa      <= '0;
            rom_wd      <= '0;
            rom_size    <= '0;
            force_bs    <= '0;
            sc          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            r_dl_prev <= ioctl_download;
            rom_we    <= w_accept;
            done      <= 1'b0;
            if (w_accept) begin
                rom_wa <= ioctl_addr[ADDR_W-1:0];
                rom_wd <= ioctl_dout;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_rise | r_rise_pend) begin
                        r_state     <= S_LOAD;
                        busy        <= 1'b1;
                        r_rise_pend <= 1'b0;
                        r_size      <= '0;
                        r_sc_data   <= 1'b1;
                        r_ref       <= '0;
                        r_mode      <= sc_mode;
                        r_bs        <= w_bs_dec;
                        r_ext_s     <= (ioctl_file_ext[7:0] == "S");
                    end else begin
                        busy <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (w_accept) begin
                        if (w_end > r_size)
                            r_size <= w_end;
                        // Relies on ascending order: byte 0 arrives first.
                        if (w_addr_zero)
                            r_ref <= ioctl_dout;
                        else if (w_low_page && (ioctl_dout != r_ref))
                            r_sc_data <= 1'b0;
                    end
                    if (w_fall)
                        r_state <= S_FINAL;
                end

                S_FINAL: begin
                    rom_size <= r_size;
                    force_bs <= r_bs;
                    case (r_mode)
                        2'd1:    sc <= 1'b0;
                        2'd2,
                        2'd3:    sc <= 1'b1;
                        default: sc <= w_sc_auto;
                    endcase
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                    // A download that restarts right here is picked up in IDLE.
                    if (w_rise)
                        r_rise_pend <= 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cart_loader
//  Description : Directed self-checking bench for cart_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cart_loader;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [31:0] ioctl_file_ext = '0;
    logic [1:0]  sc_mode = '0;
    logic        rom_we;
    logic [15:0] rom_wa;
    logic [7:0]  rom_wd;
    logic [16:0] rom_size;
    logic [3:0]  force_bs;
    logic        sc;
    logic        busy;
    logic        done;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] e_wa = '0;
    logic [7:0]  e_wd = '0;
    logic [7:0]  img [16384];

    cart_loader #(.ADDR_W(16)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_file_ext (ioctl_file_ext),
        .sc_mode        (sc_mode),
        .rom_we         (rom_we),
        .rom_wa         (rom_wa),
        .rom_wd         (rom_wd),
        .rom_size       (rom_size),
        .force_bs       (force_bs),
        .sc             (sc),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One write strobe; the registered ROM port must show it right after the edge.
    task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit acc);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
        if (acc) begin
            e_wa = a[15:0];
            e_wd = d;
        end
        chk("rom_write", {7'd0, rom_we, rom_wa, rom_wd}, {7'd0, acc, e_wa, e_wd});
    endtask

    task automatic start(input logic [31:0] ext, input logic [1:0] mode);
        ioctl_file_ext = ext;
        sc_mode        = mode;
        ioctl_download = 1'b1;
        tick();
        chk("busy_rise", {31'd0, busy}, 32'd1);
        chk("done_start", {31'd0, done}, 32'd0);
    endtask

    task automatic end_dl(input bit already_low, input logic [16:0] sz,
                          input logic [3:0] bs, input bit s);
        if (!already_low) begin
            ioctl_download = 1'b0;
            tick();
            chk("done_early", {31'd0, done}, 32'd0);
        end
        tick();
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_final", {31'd0, busy}, 32'd1);
        chk("rom_size", {15'd0, rom_size}, {15'd0, sz});
        chk("force_bs", {28'd0, force_bs}, {28'd0, bs});
        chk("sc", {31'd0, sc}, {31'd0, s});
        tick();
        chk("done_end", {31'd0, done}, 32'd0);
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_we", {31'd0, rom_we}, 32'd0);
        chk("rst_wa", {16'd0, rom_wa}, 32'd0);
        chk("rst_wd", {24'd0, rom_wd}, 32'd0);
        chk("rst_size", {15'd0, rom_size}, 32'd0);
        chk("rst_bs", {28'd0, force_bs}, 32'd0);
        chk("rst_sc", {31'd0, sc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);

        // 4 KB ramp, unknown extension
        start(".BIN", 2'd0);
        for (int i = 0; i < 4096; i++) wr(25'(i), 8'(i), 1'b1);
        end_dl(1'b0, 17'd4096, 4'd0, 1'b0);

        // 8 KB F8, uniform first page -> SuperChip detected
        start(".F8", 2'd0);
        for (int i = 0; i < 8192; i++)
            wr(25'(i), (i < 256) ? 8'hFF : (8'(i) ^ 8'h3C), 1'b1);
        end_dl(1'b0, 17'd8192, 4'd1, 1'b1);

        // Same image with one differing byte in the first page
        start(".F8", 2'd0);
        for (int i = 0; i < 8192; i++)
            wr(25'(i), (i == 128) ? 8'h00 : ((i < 256) ? 8'hFF : (8'(i) ^ 8'h3C)), 1'b1);
        end_dl(1'b0, 17'd8192, 4'd1, 1'b0);

        // "S" suffix forces SuperChip in auto, mode 1 overrides it
        for (int i = 0; i < 16384; i++) img[i] = 8'($urandom);
        start(".F6S", 2'd0);
        for (int i = 0; i < 16384; i++) wr(25'(i), img[i], 1'b1);
        end_dl(1'b0, 17'd16384, 4'd2, 1'b1);
        start(".F6S", 2'd1);
        for (int i = 0; i < 16384; i++) wr(25'(i), img[i], 1'b1);
        end_dl(1'b0, 17'd16384, 4'd2, 1'b0);

        // Out-of-range addresses are dropped
        start(".E0", 2'd0);
        wr(25'h0_0000, 8'h01, 1'b1);
        wr(25'h1_0000, 8'h22, 1'b0);
        wr(25'h1_FFFF, 8'h33, 1'b0);
        end_dl(1'b0, 17'd1, 4'd4, 1'b0);

        // Last byte gives the full 64 KB; mode 2 forces SuperChip
        start(".F0", 2'd2);
        wr(25'h0_0000, 8'h07, 1'b1);
        wr(25'h0_FFFF, 8'h09, 1'b1);
        end_dl(1'b0, 17'd65536, 4'd13, 1'b1);

        // No writes at all: size 0, auto sc from the "S" suffix only
        start(".32S", 2'd0);
        end_dl(1'b0, 17'd0, 4'd14, 1'b1);

        // Reset in the middle of a load
        start(".FE", 2'd0);
        for (int i = 0; i < 100; i++) wr(25'(i), 8'h55, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e_wa = '0;
        e_wd = '0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_size", {15'd0, rom_size}, 32'd0);
        chk("mid_rst_bs", {28'd0, force_bs}, 32'd0);
        chk("mid_rst_sc", {31'd0, sc}, 32'd0);
        for (int i = 100; i < 105; i++) wr(25'(i), 8'h66, 1'b0);
        ioctl_download = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_rst_no_done", {31'd0, done}, 32'd0);
            chk("mid_rst_idle", {31'd0, busy}, 32'd0);
        end

        // Next download after reset, last write coincident with the fall
        start(".UA", 2'd0);
        for (int i = 0; i < 2047; i++) wr(25'(i), 8'(i), 1'b1);
        ioctl_download = 1'b0;
        wr(25'd2047, 8'hAB, 1'b1);
        end_dl(1'b1, 17'd2048, 4'd11, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cart_loader.md
# cart_loader

Cartridge load stage between the HPS ioctl download stream and the console core. It registers ROM writes into the cartridge RAM and tracks the loaded image size. It decodes the file extension into a bank-switch scheme and decides SuperChip RAM enable from the extension, the OSD setting and the image contents. Its results are latched once per download and held stable for the core until the next download.

## Interface
Parameters:
- ADDR_W, 16: ROM address width; capacity 2^ADDR_W bytes (64 KB).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  high for the duration of a file transfer.
- ioctl_wr  in  1  one-cycle strobe, data valid.
- ioctl_addr  in  25  byte address of ioctl_dout.
- ioctl_dout  in  8  download data byte.
- ioctl_file_ext  in  32  ASCII extension, right-aligned, space/NUL padded.
- sc_mode  in  2  SuperChip select: 0 auto, 1 disable, 2/3 enable; sampled at download start.
- rom_we  out  1  ROM write strobe.
- rom_wa  out  ADDR_W  ROM write address.
- rom_wd  out  8  ROM write data.
- rom_size  out  17  loaded byte count, 0..65536.
- force_bs  out  4  bank-switch scheme code, 0 = size-based auto.
- sc  out  1  SuperChip RAM enable.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when results are valid.

## Operation
- FSM states: IDLE, LOAD, FINAL.
  - IDLE→LOAD on a rising edge of ioctl_download.
  - LOAD→FINAL on a falling edge of ioctl_download.
  - FINAL→IDLE unconditionally after one cycle.
- On entry to LOAD:
  - Clear size counter, sc_data flag and ref byte.
  - Set sc_data to 1.
  - Latch sc_mode.
  - Decode the extension.
- Extension normalisation: ext = (ioctl_file_ext[23:16]==".") ? ioctl_file_ext[23:0] : ioctl_file_ext[31:8].
- Scheme codes: .F8 1, .F6 2, .FE 3, .E0 4, .3F 5, .F4 6, .P2 7, .FA 8, .CV 9, .UA 11, .E7 12, .F0 13, .32 14; any other extension 0.
- A write is accepted only in LOAD, with ioctl_wr=1 and ioctl_addr[24:ADDR_W]==0. Accepted writes drive rom_we/rom_wa/rom_wd. Rejected writes produce no rom_we and no size update.
- Size tracking: on an accepted write, size = max(size, ioctl_addr[15:0]+1). The computation is 17-bit, so address 0xFFFF gives 65536.
- SuperChip content check:
  - Address 0 stores the ref byte.
  - Addresses 1..255 whose data differs from the ref byte clear sc_data.
  - This assumes ascending address order; address 0 is always written first.
- SuperChip decision in FINAL:
  - mode 1: sc = 0.
  - mode 2/3: sc = 1.
  - mode 0: sc = (ioctl_file_ext[7:0]=="S") | (sc_data & size ∈ {8192, 16384, 32768}).
- FINAL actions: latch rom_size, force_bs and sc; pulse done.
- Outputs then hold until the next FINAL or reset.
- ROM contents are never cleared by this block.

## Timing
- Reset values:
  - rom_we 0, rom_wa 0, rom_wd 0.
  - rom_size 0, force_bs 0, sc 0.
  - busy 0, done 0.
  - FSM in IDLE.
- Write latency: rom_we/rom_wa/rom_wd are registered, asserted exactly 1 cycle after ioctl_wr, for 1 cycle.
- busy = 1 in LOAD and FINAL. It rises 1 cycle after the download rising edge and falls together with the done pulse's end.
- done is high for exactly 1 cycle, 2 cycles after ioctl_download falls.
- ioctl_wr in the same cycle as ioctl_download falls is still accepted. The write lands before FINAL and is included in size.
- Download with zero accepted writes: rom_size 0, sc follows mode; in auto sc = extension-"S" only.
- Reset mid-LOAD:
  - Abort to IDLE with all outputs at reset values.
  - The remainder of that download is ignored until a fresh rising edge of ioctl_download.
- A new rising edge while in FINAL is not missed: the edge detector is registered and processed in IDLE the next cycle.

## Test plan
- Load a 4096-byte ramp, ext "BIN" -> 4096 rom_we pulses, each 1 cycle after ioctl_wr with matching addr/data; done once; rom_size 4096; force_bs 0; sc 0.
- Load 8192 bytes, ext ".F8", sc_mode 0, bytes 0..255 = 0xFF -> force_bs 1, sc 1, rom_size 8192. Repeat with byte 0x80 = 0x00 -> sc 0.
- Ext "F6S", sc_mode 0, 16384 random bytes -> force_bs 2, sc 1. Same file with sc_mode 1 -> sc 0.
- Write to ioctl_addr 0x10000 and 0x1FFFF during load -> no rom_we, rom_size unaffected. Write to 0xFFFF -> rom_size 65536.
- Assert reset after 100 writes mid-load -> busy 0, done never pulses, rom_size/force_bs/sc 0. The next full download completes normally.
- ioctl_wr coincident with the ioctl_download falling edge at addr 2047 -> write performed; rom_size 2048; done 2 cycles later.
